// File: rtl/alu_multicycle.sv
// Multicycle ALU: logic/add/sub in one cycle, iterative shift-add MUL and restoring DIV.
// Define ALU_MULTICYCLE_DIV_EN to build the divider; otherwise DIV reports divide-by-zero.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opa_nxt;
    logic [WIDTH-1:0] opb, opb_nxt;
    logic [WIDTH-1:0] prod, prod_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             zero_nxt, carry_nxt, ovf_nxt, dz_nxt;

    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] res;
    logic             res_c, res_o, res_d;
    logic             multi;
    logic             accept;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] fin;

`ifdef ALU_MULTICYCLE_DIV_EN
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             div_op, div_op_nxt;
    logic [WIDTH:0]   rem_sh, rem_dif;
    logic [WIDTH-1:0] quo;
`endif

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Single-cycle results, decoded straight from the offered operands
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res   = '0;
        res_c = 1'b0;
        res_o = 1'b0;
        res_d = 1'b0;
        multi = 1'b0;
        unique case (f)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_o = (a[WIDTH-1] == b[WIDTH-1])
                     && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = dif[WIDTH-1:0];
                res_c = dif[WIDTH];
                res_o = (a[WIDTH-1] != b[WIDTH-1])
                     && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:  multi = 1'b1;
            OP_DIV: begin
`ifdef ALU_MULTICYCLE_DIV_EN
                if (b == '0) begin
                    res   = '1;
                    res_d = 1'b1;
                end else begin
                    multi = 1'b1;
                end
`else
                res_d = 1'b1;
`endif
            end
            default: res = '0;
        endcase
    end

    // One iteration step of the multicycle datapath
    always_comb begin
        mul_sum = prod + (opb[0] ? opa : '0);
`ifdef ALU_MULTICYCLE_DIV_EN
        rem_sh  = {rem, opa[WIDTH-1]};
        rem_dif = rem_sh - {1'b0, opb};
        quo     = {opa[WIDTH-2:0], ~rem_dif[WIDTH]};
        fin     = div_op ? quo : mul_sum;
`else
        fin     = mul_sum;
`endif
    end

    always_comb begin
        state_nxt = state;
        opa_nxt   = opa;
        opb_nxt   = opb;
        prod_nxt  = prod;
        cnt_nxt   = cnt;
        y_nxt     = y;
        zero_nxt  = zero;
        carry_nxt = carry;
        ovf_nxt   = ovf;
        dz_nxt    = dz;
`ifdef ALU_MULTICYCLE_DIV_EN
        rem_nxt    = rem;
        div_op_nxt = div_op;
`endif
        unique case (state)
            IDLE: begin
                if (accept && multi) begin
                    state_nxt = BUSY;
                    opa_nxt   = a;
                    opb_nxt   = b;
                    prod_nxt  = '0;
                    cnt_nxt   = '0;
`ifdef ALU_MULTICYCLE_DIV_EN
                    rem_nxt    = '0;
                    div_op_nxt = (f == OP_DIV);
`endif
                end else if (accept) begin
                    state_nxt = DONE;
                    y_nxt     = res;
                    zero_nxt  = (res == '0);
                    carry_nxt = res_c;
                    ovf_nxt   = res_o;
                    dz_nxt    = res_d;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
                if (div_op) begin
                    rem_nxt = rem_dif[WIDTH] ? rem_sh[WIDTH-1:0]
                                             : rem_dif[WIDTH-1:0];
                    opa_nxt = quo;
                end else begin
                    prod_nxt = mul_sum;
                    opa_nxt  = opa << 1;
                    opb_nxt  = opb >> 1;
                end
`else
                prod_nxt = mul_sum;
                opa_nxt  = opa << 1;
                opb_nxt  = opb >> 1;
`endif
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    y_nxt     = fin;
                    zero_nxt  = (fin == '0);
                    carry_nxt = 1'b0;
                    ovf_nxt   = 1'b0;
                    dz_nxt    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            prod  <= '0;
            cnt   <= '0;
            y     <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            rem    <= '0;
            div_op <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            prod  <= prod_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            zero  <= zero_nxt;
            carry <= carry_nxt;
            ovf   <= ovf_nxt;
            dz    <= dz_nxt;
`ifdef ALU_MULTICYCLE_DIV_EN
            rem    <= rem_nxt;
            div_op <= div_op_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed bench for alu_multicycle (WIDTH=32)
// against an arithmetic reference model.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        zero, carry, ovf, dz;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        z, c, o, d;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] y;
        logic        z, c, o, d;
        int          lat;
        bit          offer_ready;
        bit          busy_ready;
        bit          stable;
        bit          idle_after;
    } obs_t;

    function automatic exp_t model(input logic [31:0] ma, mb,
                                   input logic [2:0] mf);
        exp_t        e;
        longint      sa, sb, sr;
        logic [63:0] w;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        e.y = '0; e.c = 0; e.o = 0; e.d = 0; e.lat = 1;
        case (mf)
            3'd0: e.y = ma & mb;
            3'd1: e.y = ma | mb;
            3'd2: e.y = ~(ma & mb);
            3'd3: e.y = ~(ma | mb);
            3'd4: begin
                w   = 64'(ma) + 64'(mb);
                e.y = w[31:0];
                e.c = w[32];
                sr  = sa + sb;
                e.o = (sr != longint'($signed(e.y)));
            end
            3'd5: begin
                e.y = ma - mb;
                e.c = (ma >= mb);
                sr  = sa - sb;
                e.o = (sr != longint'($signed(e.y)));
            end
            3'd6: begin
                w     = 64'(ma) * 64'(mb);
                e.y   = w[31:0];
                e.lat = 33;
            end
            default: begin
`ifdef ALU_MULTICYCLE_DIV_EN
                if (mb == 0) begin
                    e.y = 32'hFFFF_FFFF;
                    e.d = 1;
                end else begin
                    e.y   = ma / mb;
                    e.lat = 33;
                end
`else
                e.y = 0;
                e.d = 1;
`endif
            end
        endcase
        e.z = (e.y == 0);
        return e;
    endfunction

    // Offer one op, wait for the result, hold it for `hold` cycles, then take it
    task automatic do_op(input logic [31:0] oa, ob, input logic [2:0] of,
                         input int hold, input bit keep_valid,
                         output obs_t o);
        o.offer_ready = in_ready;
        a = oa; b = ob; f = of;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        a = $urandom; b = $urandom; f = 3'($urandom);
        o.lat = 1;
        o.busy_ready = 0;
        while (!out_valid && o.lat < 100) begin
            if (in_ready) o.busy_ready = 1;
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            o.lat++;
        end
        o.y = y; o.z = zero; o.c = carry; o.o = ovf; o.d = dz;
        o.stable = 1;
        repeat (hold) begin
            if (in_ready) o.busy_ready = 1;
            @(posedge clk); #1;
            a = $urandom; b = $urandom; f = 3'($urandom);
            if (!out_valid || y !== o.y
                || {zero, carry, ovf, dz} !== {o.z, o.c, o.o, o.d})
                o.stable = 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        o.idle_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (y !== 32'h0)
            $display("FAIL reset_y got %h want 0", y);
        else pass_cnt++;
        total_cnt++;
        if ({zero, carry, ovf, dz} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000",
                     {zero, carry, ovf, dz});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL post_reset_ready got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [2:0]  vf[6];
        logic [31:0] vy[6];
        obs_t        o;
        exp_t        e;
        va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
               32'h0001_0003, 32'd100, 32'd5};
        vb = '{32'd1, 32'd1, 32'h0, 32'h0001_0000, 32'd7, 32'd0};
        vf = '{3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd7};
`ifdef ALU_MULTICYCLE_DIV_EN
        vy = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
               32'h0003_0000, 32'd14, 32'hFFFF_FFFF};
`else
        vy = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
               32'h0003_0000, 32'd0, 32'd0};
`endif
        for (int i = 0; i < 6; i++) begin
            e = model(va[i], vb[i], vf[i]);
            do_op(va[i], vb[i], vf[i], 0, 0, o);
            total_cnt++;
            if (o.y !== vy[i])
                $display("FAIL dir%0d_y got %h want %h", i, o.y, vy[i]);
            else pass_cnt++;
            total_cnt++;
            if ({o.z, o.c, o.o, o.d} !== {e.z, e.c, e.o, e.d})
                $display("FAIL dir%0d_flags got %b want %b", i,
                         {o.z, o.c, o.o, o.d}, {e.z, e.c, e.o, e.d});
            else pass_cnt++;
            total_cnt++;
            if (o.lat != e.lat)
                $display("FAIL dir%0d_latency got %0d want %0d",
                         i, o.lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if (o.busy_ready || !o.idle_after)
                $display("FAIL dir%0d_ready busy=%b idle=%b want 0/1",
                         i, o.busy_ready, o.idle_after);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_op(32'd3, 32'd4, 3'd4, 5, 1, o);
        total_cnt++;
        if (o.y !== 32'd7)
            $display("FAIL bp_y got %h want 7", o.y);
        else pass_cnt++;
        total_cnt++;
        if (!o.stable)
            $display("FAIL bp_stable got 0 want 1");
        else pass_cnt++;
        total_cnt++;
        if (o.busy_ready)
            $display("FAIL bp_in_ready got 1 want 0");
        else pass_cnt++;
        total_cnt++;
        if (!o.idle_after)
            $display("FAIL bp_idle_after got 0 want 1");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        bit   seen;
        a = 32'h0001_0003; b = 32'h0001_0000; f = 3'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || y !== 32'h0 || in_ready !== 1'b0)
            $display("FAIL midrst_state got ov=%b y=%h rdy=%b want 0/0/0",
                     out_valid, y, in_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL midrst_ready got %b want 1", in_ready);
        else pass_cnt++;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        total_cnt++;
        if (seen)
            $display("FAIL midrst_no_result got out_valid want none");
        else pass_cnt++;
        do_op(32'd1, 32'd1, 3'd4, 0, 0, o);
        total_cnt++;
        if (o.y !== 32'd2)
            $display("FAIL midrst_add got %h want 2", o.y);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        exp_t        e;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0
                 : ($urandom_range(0, 1) ? $urandom
                                         : 32'($urandom_range(1, 300)));
            rf = 3'($urandom);
            e = model(ra, rb, rf);
            do_op(ra, rb, rf, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), o);
            total_cnt++;
            if (o.y !== e.y || {o.z, o.c, o.o, o.d}
                               !== {e.z, e.c, e.o, e.d})
                $display("FAIL rnd%0d f=%0d a=%h b=%h got %h/%b want %h/%b",
                         i, rf, ra, rb, o.y, {o.z, o.c, o.o, o.d},
                         e.y, {e.z, e.c, e.o, e.d});
            else pass_cnt++;
            total_cnt++;
            if (o.lat != e.lat || !o.offer_ready || !o.stable)
                $display("FAIL rnd%0d_timing got lat=%0d rdy=%b st=%b want %0d/1/1",
                         i, o.lat, o.offer_ready, o.stable, e.lat);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        f         = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits, legal range 4..64.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand/opcode offer.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a, b  input  WIDTH each  operands, unsigned unless stated.
REQ-007 f  input  3  opcode: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 ADD, 101 SUB, 110 MUL, 111 DIV.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 y  output  WIDTH  result.
REQ-011 zero, carry, ovf, dz  output  1 each  flags, valid with out_valid.

Function
REQ-012 States SHALL be IDLE, BUSY, DONE; in_ready SHALL equal (state==IDLE), combinationally.
REQ-013 Accept SHALL occur on a clock edge with in_valid&&in_ready; a, b, f SHALL be registered then, later input changes ignored.
REQ-014 AND/OR/NAND/NOR/ADD/SUB: IDLE->DONE on accept edge; out_valid high from the next cycle (latency 1).
REQ-015 ADD/SUB: y = (a+b) or (a-b) mod 2^WIDTH; carry = carry-out of a+b, or of a+~b+1 (1 = no borrow); ovf = two's-complement signed overflow.
REQ-016 MUL: IDLE->BUSY on accept, iterative shift-add, one bit per cycle, exactly WIDTH BUSY cycles, then DONE; out_valid first high WIDTH+1 cycles after accept; y = low WIDTH bits of a*b.
REQ-017 DIV, b!=0: restoring division, same WIDTH-cycle BUSY timing as MUL; y = floor(a/b).
REQ-018 DIV, b==0: IDLE->DONE directly (latency 1); y = all ones, dz = 1.
REQ-019 zero SHALL be (y==0) for every op; carry and ovf SHALL be 0 for non-ADD/SUB ops; dz SHALL be 0 except REQ-018.
REQ-020 DONE: y and flags SHALL hold stable while out_valid && !out_ready; out_valid&&out_ready edge SHALL move to IDLE and drop out_valid.
REQ-021 No new operation SHALL be accepted in BUSY or DONE; earliest next accept is the cycle after the out handshake.
REQ-022 in_valid during BUSY/DONE SHALL have no effect.

Reset
REQ-023 rst high at a clock edge SHALL force IDLE, out_valid=0, y=0, all flags 0, internal operand/iteration registers 0, regardless of state.
REQ-024 rst mid-MUL/DIV SHALL discard the operation; no out_valid for it SHALL ever appear.
REQ-025 in_ready SHALL be 0 while rst is high and 1 the first cycle after rst deasserts.

Configuration
REQ-026 Macro ALU_MULTICYCLE_DIV_EN defined: DIV per REQ-017/018 with divider datapath present.
REQ-027 Macro undefined: no divider logic; f=111 SHALL complete with latency 1, y=0, dz=1, zero=1.

Verification (WIDTH=32)
REQ-028 ADD a=0xFFFFFFFF b=1 -> out_valid 1 cycle after accept, y=0, zero=1, carry=1, ovf=0.
REQ-029 SUB a=0x80000000 b=1 -> y=0x7FFFFFFF, ovf=1, carry=1; NOR a=0 b=0 -> y=0xFFFFFFFF.
REQ-030 MUL a=0x00010003 b=0x00010000 -> out_valid exactly 33 cycles after accept, y=0x00030000, in_ready 0 throughout.
REQ-031 DIV a=100 b=7 -> y=14 after 33 cycles; DIV a=5 b=0 -> y=0xFFFFFFFF, dz=1 after 1 cycle (without macro: y=0, dz=1).
REQ-032 ADD 3+4, out_ready low 5 cycles with a/b toggling -> y=7 stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-033 rst pulse at cycle 10 of MUL -> IDLE, y=0, out_valid never asserted for that op; following ADD 1+1 -> y=2.
